// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default framing constants
// and the baud divider derivation also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned BAUD_RATE        = 115_200;
  localparam int unsigned DEF_DATA_BITS    = 8;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

  localparam int unsigned DEF_CLKS_PER_BIT = baud_div(CLK_HZ, BAUD_RATE);

endpackage

// File: rtl/uart_rx_frontend_sync_2ff.sv
// Double-flop synchronizer for asynchronous inputs, with a selectable reset
// value so idle-high lines do not look active out of reset.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 receive front end: synchronises rx, deframes with mid-bit sampling and
// holds each byte in a one-entry valid/ready buffer with framing/overrun flags.
//
// state     | meaning
// S_IDLE    | line idle, waiting for rx_s low
// S_START   | counting to mid start bit, rejecting glitches
// S_DATA    | sampling data bits at mid-bit, LSB first
// S_STOP    | sampling stop bit; completes byte or flags framing error
// S_WAIT_HIGH | break/low line after framing error, wait for rx_s high
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  input  logic                 i_clr_err,
  output logic                 o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS) + 1;
  localparam int unsigned H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 byte_done;
  logic                 frame_err_d;
  logic                 pop;
  logic                 load;
  logic                 overrun_set;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d;
  logic                 overrun_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= frame_err_d;
      o_overrun   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle as completion frees the slot for the new byte.
  always_comb begin
    pop         = o_valid & i_ready;
    load        = byte_done & (~o_valid | pop);
    overrun_set = byte_done & o_valid & ~pop;
    data_d      = load ? shreg_q : o_data;
    valid_d     = load | (o_valid & ~pop);
    overrun_d   = overrun_set | (o_overrun & ~i_clr_err);
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend at 16 clocks/bit, 8 data bits:
// scoreboard queue of expected bytes plus per-scenario directed checks.
module tb_uart_rx_frontend;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int LAT = 154;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_frame_err;
  logic          o_overrun;
  logic          i_clr_err = 1'b0;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int v_rises = 0;
  int v_rise_cyc = 0;
  int fe_cnt = 0;
  logic prev_v = 1'b0;
  logic [DB-1:0] exp_q[$];

  uart_rx_frontend #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr_err   (i_clr_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_v <= o_valid;
    if (o_valid && !prev_v) begin
      v_rises    <= v_rises + 1;
      v_rise_cyc <= cyc;
    end
    if (o_frame_err) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Drives start, data LSB first and the given stop level; rx stays at stop level.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    @(posedge clk); #1;
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < DB; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic pop_once();
    @(posedge clk); #1 i_ready = 1'b1;
    @(posedge clk); #1 i_ready = 1'b0;
  endtask

  task automatic check_byte(input string name);
    logic [DB-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, o_data=%h", name, o_data);
    end else begin
      exp = exp_q.pop_front();
      if (o_data !== exp) begin
        errors++;
        $display("FAIL %s: o_data got %h expected %h", name, o_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", o_frame_err); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", o_overrun); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_clean_byte();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b expected 1", o_valid); end
    check_byte("clean_data");
    checks++; if (v_rise_cyc !== start_cyc + 1 + LAT) begin errors++; $display("FAIL clean_latency: rise at %0d expected %0d", v_rise_cyc, start_cyc + 1 + LAT); end
    pop_once();
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clean_pop: o_valid got %b expected 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clean_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_glitch();
    int vr0, fe0;
    vr0 = v_rises; fe0 = fe_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    start_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    wait_cyc(start_cyc + 10);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hold: got %b expected 1", o_busy); end
    wait_cyc(start_cyc + 11);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b expected 0", o_busy); end
    repeat (CPB * 4) @(negedge clk);
    checks++; if (v_rises !== vr0) begin errors++; $display("FAIL glitch_valid: rises %0d expected %0d", v_rises, vr0); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_fe: pulses %0d expected %0d", fe_cnt, fe0); end
  endtask

  task automatic test_frame_err();
    int vr0, fe0;
    vr0 = v_rises; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL fe_pulse: count %0d expected %0d", fe_cnt, fe0 + 1); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL fe_wait_high: busy %b expected 1", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fe_no_valid: got %b expected 0", o_valid); end
    #1 rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL fe_idle: busy %b expected 0", o_busy); end
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL fe_single: count %0d expected %0d", fe_cnt, fe0 + 1); end
    checks++; if (v_rises !== vr0) begin errors++; $display("FAIL fe_no_byte: rises %0d expected %0d", v_rises, vr0); end
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fe_next_valid: got %b expected 1", o_valid); end
    check_byte("fe_next_data");
    pop_once();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", o_valid); end
    check_byte("ovr_keep_old");
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", o_overrun); end
    @(posedge clk); #1 i_clr_err = 1'b1;
    @(posedge clk); #1 i_clr_err = 1'b0;
    @(negedge clk);
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", o_overrun); end
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1);
      begin
        @(posedge clk); #2;
        wait_cyc(start_cyc + LAT);
        i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
      end
    join
    @(negedge clk);
    check_byte("pop_same_edge_data");
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pop_same_edge_valid: got %b expected 1", o_valid); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL pop_same_edge_ovr: got %b expected 0", o_overrun); end
  endtask

  task automatic test_reset_mid_frame();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk); #2;
        wait_cyc(start_cyc + 2 + 8 + 3 * CPB + 8);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", o_busy); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", o_data); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rstmid_ovr: got %b expected 0", o_overrun); end
      end
    join
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: valid %b fe %b busy %b expected 0 0 0", o_valid, o_frame_err, o_busy); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next_valid: got %b expected 1", o_valid); end
    check_byte("rstmid_next_data");
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
